// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: registered N-way channel selector with valid/ready handshakes.
// The grant is picked by explicit select, fixed priority or round-robin.
// One output register stage carries the chosen word and its channel index.
// The output slot reloads in the same cycle it drains, so there is no bubble.
module rr_mux_arbiter #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SELW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [1:0]                mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("rr_mux_arbiter: CHANNELS must be in 2..16");
  end

  localparam logic [1:0] MODE_SEL = 2'd0;
  localparam logic [1:0] MODE_PRI = 2'd1;

  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_chan_q,  out_chan_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q,       ptr_d;

  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic                found;
  logic                load;
  logic                xfer;
  logic [WIDTH-1:0]    grant_data;
  logic [SELW-1:0]     grant_idx;

  // The slot can accept a word when it is empty or is being drained this cycle.
  assign load      = !out_valid_q || out_ready;
  assign grant_any = |grant;
  assign xfer      = grant_any && load && !rst;
  assign in_ready  = (load && !rst) ? grant : '0;

  // Grant decision: one-hot or zero, re-evaluated every cycle.
  // Round-robin runs two passes (indices at/above the pointer, then below it)
  // so every index into in_valid is a loop constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    case (mode)
      MODE_SEL: begin
        // An out-of-range sel matches no channel, so nothing is granted.
        for (int i = 0; i < CHANNELS; i++) begin
          if (SELW'(i) == sel) grant[i] = in_valid[i];
        end
      end
      MODE_PRI: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && in_valid[i] && (SELW'(i) >= ptr_q)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && in_valid[i] && (SELW'(i) < ptr_q)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    endcase
  end

  // Data and index of the granted channel; both are zero when nothing is granted.
  always_comb begin
    grant_data = '0;
    grant_idx  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        grant_idx  = SELW'(i);
      end
    end
  end

  // Next state of the output slot and of the round-robin pointer.
  // mode[1] covers both the round-robin code and the spare code 3.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = grant_data;
        out_chan_d = grant_idx;
      end
    end
    if (xfer && mode[1]) begin
      ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State registers; reset clears the slot immediately and discards in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a directed vector table on a 4-channel instance,
// plus short sequences on 3- and 5-channel instances and a mid-stream reset.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [63:0] d4_in_data;
  logic [3:0]  d4_in_valid, d4_in_ready;
  logic [1:0]  d4_mode, d4_sel, d4_out_chan;
  logic [15:0] d4_out_data;
  logic        d4_out_valid, d4_out_ready;

  // 3-channel instance
  logic [47:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_ready;
  logic [1:0]  d3_mode, d3_sel, d3_out_chan;
  logic [15:0] d3_out_data;
  logic        d3_out_valid, d3_out_ready;

  // 5-channel instance
  logic [79:0] d5_in_data;
  logic [4:0]  d5_in_valid, d5_in_ready;
  logic [1:0]  d5_mode;
  logic [2:0]  d5_sel, d5_out_chan;
  logic [15:0] d5_out_data;
  logic        d5_out_valid, d5_out_ready;

  rr_mux_arbiter #(.WIDTH(16), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(d4_in_data), .in_valid(d4_in_valid),
    .in_ready(d4_in_ready), .mode(d4_mode), .sel(d4_sel), .out_data(d4_out_data),
    .out_chan(d4_out_chan), .out_valid(d4_out_valid), .out_ready(d4_out_ready));

  rr_mux_arbiter #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
    .out_chan(d3_out_chan), .out_valid(d3_out_valid), .out_ready(d3_out_ready));

  rr_mux_arbiter #(.WIDTH(16), .CHANNELS(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(d5_in_data), .in_valid(d5_in_valid),
    .in_ready(d5_in_ready), .mode(d5_mode), .sel(d5_sel), .out_data(d5_out_data),
    .out_chan(d5_out_chan), .out_valid(d5_out_valid), .out_ready(d5_out_ready));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [63:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_chan;
    logic [15:0] exp_data;
  } vec_t;

  localparam int NV = 21;
  localparam logic [63:0] D_STD  = 64'h000D_000C_000B_000A;
  localparam logic [63:0] D_BEEF = 64'h000D_BEEF_000B_000A;

  vec_t vecs [NV];

  initial begin
    // round-robin over all four channels from reset (pointer 0)
    vecs[0]  = '{2'd2, 2'd0, 4'b1111, 1'b1, D_STD,  4'b0001, 1'b1, 2'd0, 16'h000A};
    vecs[1]  = '{2'd2, 2'd0, 4'b1111, 1'b1, D_STD,  4'b0010, 1'b1, 2'd1, 16'h000B};
    vecs[2]  = '{2'd2, 2'd0, 4'b1111, 1'b1, D_STD,  4'b0100, 1'b1, 2'd2, 16'h000C};
    vecs[3]  = '{2'd2, 2'd0, 4'b1111, 1'b1, D_STD,  4'b1000, 1'b1, 2'd3, 16'h000D};
    vecs[4]  = '{2'd2, 2'd0, 4'b1111, 1'b1, D_STD,  4'b0001, 1'b1, 2'd0, 16'h000A};
    // fixed priority, channels 1 and 3, then channel 1 withdrawn
    vecs[5]  = '{2'd1, 2'd0, 4'b1010, 1'b1, D_STD,  4'b0010, 1'b1, 2'd1, 16'h000B};
    vecs[6]  = '{2'd1, 2'd0, 4'b1010, 1'b1, D_STD,  4'b0010, 1'b1, 2'd1, 16'h000B};
    vecs[7]  = '{2'd1, 2'd0, 4'b1010, 1'b1, D_STD,  4'b0010, 1'b1, 2'd1, 16'h000B};
    vecs[8]  = '{2'd1, 2'd0, 4'b1000, 1'b1, D_STD,  4'b1000, 1'b1, 2'd3, 16'h000D};
    // explicit select
    vecs[9]  = '{2'd0, 2'd2, 4'b0100, 1'b1, D_BEEF, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
    vecs[10] = '{2'd0, 2'd1, 4'b0100, 1'b1, D_BEEF, 4'b0000, 1'b0, 2'd0, 16'h0000};
    // back-pressure: fill (pointer 1), hold 5 cycles with mode/sel changing
    vecs[11] = '{2'd2, 2'd0, 4'b1111, 1'b0, D_STD,  4'b0010, 1'b1, 2'd1, 16'h000B};
    vecs[12] = '{2'd2, 2'd0, 4'b1111, 1'b0, D_STD,  4'b0000, 1'b1, 2'd1, 16'h000B};
    vecs[13] = '{2'd0, 2'd3, 4'b1111, 1'b0, D_STD,  4'b0000, 1'b1, 2'd1, 16'h000B};
    vecs[14] = '{2'd0, 2'd3, 4'b1111, 1'b0, D_STD,  4'b0000, 1'b1, 2'd1, 16'h000B};
    vecs[15] = '{2'd1, 2'd0, 4'b1111, 1'b0, D_STD,  4'b0000, 1'b1, 2'd1, 16'h000B};
    vecs[16] = '{2'd2, 2'd0, 4'b1111, 1'b0, D_STD,  4'b0000, 1'b1, 2'd1, 16'h000B};
    // drain and reload in one cycle; pointer 2 wraps to channel 0
    vecs[17] = '{2'd2, 2'd0, 4'b0001, 1'b1, D_STD,  4'b0001, 1'b1, 2'd0, 16'h000A};
    vecs[18] = '{2'd2, 2'd0, 4'b0000, 1'b1, D_STD,  4'b0000, 1'b0, 2'd0, 16'h0000};
    // mode 3 behaves as round-robin (pointer 1, then 2)
    vecs[19] = '{2'd3, 2'd0, 4'b1111, 1'b1, D_STD,  4'b0010, 1'b1, 2'd1, 16'h000B};
    vecs[20] = '{2'd3, 2'd0, 4'b0011, 1'b1, D_STD,  4'b0001, 1'b1, 2'd0, 16'h000A};
  end

  initial begin
    rst = 1'b1;
    d4_in_data = D_STD; d4_in_valid = 4'b1111; d4_mode = 2'd2; d4_sel = 2'd0; d4_out_ready = 1'b1;
    d3_in_data = '0; d3_in_valid = '0; d3_mode = 2'd0; d3_sel = 2'd0; d3_out_ready = 1'b1;
    d5_in_data = '0; d5_in_valid = '0; d5_mode = 2'd2; d5_sel = 3'd0; d5_out_ready = 1'b1;
    #3;
    chk("reset in_ready", d4_in_ready, 4'b0000);
    chk("reset out_valid", d4_out_valid, 1'b0);
    chk("reset out_data", d4_out_data, 16'h0000);
    chk("reset out_chan", d4_out_chan, 2'd0);
    tick();
    tick();
    rst = 1'b0;

    // vector table on the 4-channel instance
    for (int i = 0; i < NV; i++) begin
      d4_mode      = vecs[i].mode;
      d4_sel       = vecs[i].sel;
      d4_in_valid  = vecs[i].valid;
      d4_out_ready = vecs[i].ordy;
      d4_in_data   = vecs[i].data;
      #1;
      chk($sformatf("v%0d in_ready", i), d4_in_ready, vecs[i].exp_rdy);
      tick();
      chk($sformatf("v%0d out_valid", i), d4_out_valid, vecs[i].exp_ov);
      if (vecs[i].exp_ov) begin
        chk($sformatf("v%0d out_chan", i), d4_out_chan, vecs[i].exp_chan);
        chk($sformatf("v%0d out_data", i), d4_out_data, vecs[i].exp_data);
      end
    end
    d4_in_valid = '0;

    // 3 channels: explicit select, then an out-of-range sel
    d3_mode = 2'd0; d3_sel = 2'd2; d3_in_valid = 3'b100;
    d3_in_data = 48'hBEEF_0002_0001;
    #1;
    chk("c3 sel2 in_ready", d3_in_ready, 3'b100);
    tick();
    chk("c3 sel2 out_valid", d3_out_valid, 1'b1);
    chk("c3 sel2 out_data", d3_out_data, 16'hBEEF);
    chk("c3 sel2 out_chan", d3_out_chan, 2'd2);
    d3_sel = 2'd3;
    #1;
    chk("c3 sel3 in_ready", d3_in_ready, 3'b000);
    tick();
    chk("c3 sel3 out_valid", d3_out_valid, 1'b0);
    d3_in_valid = '0;

    // 5 channels: park pointer at 4 via channel 3, then 4/0 alternation
    d5_mode = 2'd2;
    for (int c = 0; c < 5; c++) d5_in_data[c*16 +: 16] = 16'h0050 + 16'(c);
    d5_in_valid = 5'b01000;
    #1;
    chk("c5 prime in_ready", d5_in_ready, 5'b01000);
    tick();
    chk("c5 prime out_chan", d5_out_chan, 3'd3);
    d5_in_valid = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ec;
      ec = (k % 2 == 0) ? 3'd4 : 3'd0;
      #1;
      chk($sformatf("c5 alt%0d in_ready", k), d5_in_ready, 5'b00001 << ec);
      tick();
      chk($sformatf("c5 alt%0d out_valid", k), d5_out_valid, 1'b1);
      chk($sformatf("c5 alt%0d out_chan", k), d5_out_chan, ec);
      chk($sformatf("c5 alt%0d out_data", k), d5_out_data, 16'h0050 + 16'(ec));
    end
    d5_in_valid = '0;

    // mid-stream reset on the 4-channel instance (pointer is 1 here)
    d4_mode = 2'd2; d4_in_data = D_STD; d4_in_valid = 4'b1111; d4_out_ready = 1'b1;
    tick();
    chk("rst pre out_valid", d4_out_valid, 1'b1);
    chk("rst pre out_chan", d4_out_chan, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst async out_valid", d4_out_valid, 1'b0);
    chk("rst async out_data", d4_out_data, 16'h0000);
    chk("rst async out_chan", d4_out_chan, 2'd0);
    chk("rst async in_ready", d4_in_ready, 4'b0000);
    tick();
    rst = 1'b0;
    #1;
    chk("post rst in_ready", d4_in_ready, 4'b0001);
    tick();
    chk("post rst out_chan", d4_out_chan, 2'd0);
    chk("post rst out_data", d4_out_data, 16'h000A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
